// File: rtl/mult_issue_ctrl_if.sv
// mult_issue_ctrl_if: request lanes, multiplier link and CDB result port of the multiply front-end.
// master = lanes/multiplier/CDB side that drives requests, done and grant; slave = the controller.
// Carries no logic; clock and reset stay plain ports on the controller.
interface mult_issue_ctrl_if #(
  parameter int TAG_W = 6
);
  logic             req0_valid;
  logic [63:0]      req0_a;
  logic [63:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req0_ready;

  logic             req1_valid;
  logic [63:0]      req1_a;
  logic [63:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             req1_ready;

  logic             mult_start;
  logic [63:0]      mult_mcand;
  logic [63:0]      mult_mplier;
  logic             mult_done;
  logic [63:0]      mult_product;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0]      cdb_value;
  logic             cdb_grant;
  logic             err_orphan;

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_tag,
    input  req1_ready,
    input  mult_start, mult_mcand, mult_mplier,
    output mult_done, mult_product,
    input  cdb_valid, cdb_tag, cdb_value,
    output cdb_grant,
    input  err_orphan
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_tag,
    output req1_ready,
    output mult_start, mult_mcand, mult_mplier,
    input  mult_done, mult_product,
    output cdb_valid, cdb_tag, cdb_value,
    input  cdb_grant,
    output err_orphan
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: two-lane round-robin issue front-end for the 8-stage pipelined 64-bit multiplier.
// Latency: accept at T -> mult_start at T+1 -> result on the CDB at T+MULT_LAT+2 at the earliest.
// Backpressure: issue is credit-gated on result-FIFO slots; results wait in the FIFO for cdb_grant.
// Build option: MULT_FLUSH_EN adds the flush port (squash in-flight and buffered ops).
module mult_issue_ctrl #(
  parameter int MULT_LAT   = 8,
  parameter int TAG_W      = 6,
  parameter int OBUF_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MULT_FLUSH_EN
  input  logic             flush,
`endif
  mult_issue_ctrl_if.slave bus
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int MW = $clog2(MULT_LAT + 1);
  localparam logic [CW-1:0] FULL_C = CW'(OBUF_DEPTH);
  localparam logic [MW-1:0] MASK_C = MW'(MULT_LAT);

  logic flush_w;
`ifdef MULT_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // ---------------- credit and arbitration ----------------
  logic [CW-1:0] credit_q, credit_d;
  logic          prio_q, prio_d;     // lane preferred when both lanes request
  logic          issue_ok, grant0, grant1, accept;
  logic          push, pop;

  assign issue_ok = (credit_q < FULL_C) && !flush_w;
  assign accept   = grant0 | grant1;

  // Pick at most one lane: a lone requester wins, a tie goes to the lane that did not win last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (issue_ok) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = !prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Next credit and tie-break pointer; flush discards every outstanding op.
  always_comb begin
    credit_d = credit_q + CW'(accept) - CW'(pop);
    if (flush_w) credit_d = '0;
    prio_d = prio_q;
    if (accept) prio_d = grant0;
  end

  // Credit counter and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit_q <= '0;
      prio_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      prio_q   <= prio_d;
    end
  end

  // ---------------- launch registers ----------------
  logic             start_q;
  logic [63:0]      mcand_q, mplier_q;
  logic [TAG_W-1:0] ltag_q;

  // Register the winning lane's operands; operands hold when nothing launches.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ltag_q   <= '0;
    end else begin
      start_q <= accept;
      if (accept) begin
        mcand_q  <= grant0 ? bus.req0_a   : bus.req1_a;
        mplier_q <= grant0 ? bus.req0_b   : bus.req1_b;
        ltag_q   <= grant0 ? bus.req0_tag : bus.req1_tag;
      end
    end
  end

  assign bus.mult_start  = start_q;
  assign bus.mult_mcand  = mcand_q;
  assign bus.mult_mplier = mplier_q;

  // ---------------- shadow pipeline ----------------
  // Entry is taken from the launch registers, so the tail lines up with mult_done.
  logic [MULT_LAT-1:0] sh_busy_q;
  logic [TAG_W-1:0]    sh_tag_q [MULT_LAT];
  logic                tail_busy, tail_live;
  logic [TAG_W-1:0]    tail_tag;

  // Busy bits shift every cycle; reset empties the shadow of pre-reset launches.
  always_ff @(posedge clock) begin
    if (reset) sh_busy_q <= '0;
    else       sh_busy_q <= {sh_busy_q[MULT_LAT-2:0], start_q};
  end

  // Tags travel alongside the busy bits and are only meaningful where busy is set.
  always_ff @(posedge clock) begin
    sh_tag_q[0] <= ltag_q;
    for (int i = 1; i < MULT_LAT; i++) sh_tag_q[i] <= sh_tag_q[i-1];
  end

`ifdef MULT_FLUSH_EN
  logic [MULT_LAT-1:0] sh_live_q;
  // Live bits follow busy but are wiped by flush, including the op launching that cycle.
  always_ff @(posedge clock) begin
    if (reset) sh_live_q <= '0;
    else       sh_live_q <= {sh_live_q[MULT_LAT-2:0], start_q} & {MULT_LAT{!flush}};
  end
  assign tail_live = sh_live_q[MULT_LAT-1];
`else
  assign tail_live = tail_busy;
`endif

  assign tail_busy = sh_busy_q[MULT_LAT-1];
  assign tail_tag  = sh_tag_q[MULT_LAT-1];

  // ---------------- orphan detection ----------------
  logic [MW-1:0] mask_q;
  logic          err_q;

  // Dones from launches abandoned by reset can arrive for MULT_LAT cycles; ignore them.
  always_ff @(posedge clock) begin
    if (reset)              mask_q <= MASK_C;
    else if (mask_q != '0)  mask_q <= mask_q - MW'(1);
  end

  // Sticky error whenever mult_done disagrees with the shadow tail outside the mask window.
  always_ff @(posedge clock) begin
    if (reset)                                            err_q <= 1'b0;
    else if ((bus.mult_done != tail_busy) && mask_q == '0) err_q <= 1'b1;
  end

  assign bus.err_orphan = err_q;

  // ---------------- result FIFO ----------------
  logic [TAG_W-1:0] fq_tag [OBUF_DEPTH];
  logic [63:0]      fq_val [OBUF_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  assign push = bus.mult_done && tail_busy && tail_live && !flush_w;
  assign pop  = (cnt_q != '0) && bus.cdb_grant && !flush_w;

  // Pointers wrap naturally at the power-of-two depth; flush empties the queue.
  always_ff @(posedge clock) begin
    if (reset || flush_w) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      a_no_overflow: assert (!(push && cnt_q == FULL_C));
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Result storage; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) begin
      fq_tag[wr_ptr_q] <= tail_tag;
      fq_val[wr_ptr_q] <= bus.mult_product;
    end
  end

  assign bus.cdb_valid = (cnt_q != '0);
  assign bus.cdb_tag   = fq_tag[rd_ptr_q];
  assign bus.cdb_value = fq_val[rd_ptr_q];
endmodule
